output_serializer: RTL and testbench

OUTPUT_SERIALIZER -- requirements
Module: output_serializer

---
 rtl/output_serializer_if.sv | 8 +
 rtl/output_serializer.sv | 131 +++++++++++++
 tb/tb_output_serializer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/output_serializer_if.sv
// CPU output bus: one-cycle strobe with the byte on the data bus.
interface output_serializer_if;
  logic       out_strobe;
  logic [7:0] out_data;

  modport master (output out_strobe, output out_data);
  modport slave  (input  out_strobe, input  out_data);
endinterface

// File: rtl/output_serializer.sv
// Byte FIFO feeding an 8N1 serial transmitter; DIVISOR clk cycles per bit.
module output_serializer #(
  parameter int unsigned DIVISOR = 4,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                clk,
  input  logic                reset,
  output_serializer_if.slave  bus,
  output logic                tx,
  output logic                busy,
  output logic [4:0]          fifo_count,
  output logic                full,
  output logic [7:0]          dropped
);

  localparam int unsigned      PW     = $clog2(DEPTH);
  localparam logic [PW-1:0]    PONE   = 1;
  localparam logic [7:0]       TLOAD  = 8'(DIVISOR - 1);
  localparam logic [4:0]       DEPTH5 = 5'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [7:0]    timer_q, timer_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [4:0]    count_q, count_d;
  logic [7:0]    drop_q, drop_d;
  logic [7:0]    mem_q [DEPTH];
  logic          push, pop;

  // FIFO bookkeeping: pop only from IDLE with data present, so a byte
  // strobed into an empty FIFO is popped on the following edge.
  always_comb begin
    pop     = (state_q == IDLE) && (count_q != '0);
    push    = bus.out_strobe && ((count_q < DEPTH5) || pop);
    wptr_d  = push ? wptr_q + PONE : wptr_q;
    rptr_d  = pop  ? rptr_q + PONE : rptr_q;
    count_d = count_q;
    if (push && !pop) count_d = count_q + 5'd1;
    if (pop && !push) count_d = count_q - 5'd1;
    drop_d  = drop_q;
    if (bus.out_strobe && !push && (drop_q != '1)) drop_d = drop_q + 8'd1;
  end

  // Transmit FSM next-state; tx is derived from the next state so the
  // line changes on the same edge the state does.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          shift_d = mem_q[rptr_q];
          timer_d = TLOAD;
          state_d = START;
        end
      end
      START: begin
        if (timer_q == '0) begin
          state_d = DATA;
          bit_d   = '0;
          timer_d = TLOAD;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      DATA: begin
        if (timer_q == '0) begin
          shift_d = {1'b0, shift_q[7:1]};
          timer_d = TLOAD;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      STOP: begin
        if (timer_q == '0) state_d = IDLE;
        else               timer_d = timer_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // Control and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      drop_q  <= drop_d;
    end
  end

  // FIFO storage, not cleared by reset.
  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[wptr_q] <= bus.out_data;
  end

  assign tx         = tx_q;
  assign busy       = (state_q != IDLE);
  assign fifo_count = count_q;
  assign full       = (count_q == DEPTH5);
  assign dropped    = drop_q;

endmodule

// File: tb/tb_output_serializer.sv
// Directed bench for output_serializer with DIVISOR=4, DEPTH=4.
module tb_output_serializer;

  logic       clk;
  logic       reset;
  logic       tx;
  logic       busy;
  logic [4:0] fifo_count;
  logic       full;
  logic [7:0] dropped;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  output_serializer_if bus_if ();

  output_serializer #(.DIVISOR(4), .DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus_if.slave),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count),
    .full       (full),
    .dropped    (dropped)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks tx/busy from frame cycle 'from' to 39, ending at the IDLE cycle.
  task automatic check_frame(input logic [7:0] b, input int unsigned from);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int unsigned i = from; i < 40; i++) begin
      check($sformatf("tx_%02h_c%0d", b, i), {31'b0, tx}, {31'b0, fr[i/4]});
      check($sformatf("busy_%02h_c%0d", b, i), {31'b0, busy}, 32'd1);
      tick();
    end
    check($sformatf("idle_tx_%02h", b), {31'b0, tx}, 32'd1);
    check($sformatf("idle_busy_%02h", b), {31'b0, busy}, 32'd0);
  endtask

  task automatic strobe(input logic [7:0] d);
    bus_if.out_strobe = 1'b1;
    bus_if.out_data   = d;
    tick();
    bus_if.out_strobe = 1'b0;
    bus_if.out_data   = 8'h00;
  endtask

  logic saw_low;

  initial begin
    bus_if.out_strobe = 1'b0;
    bus_if.out_data   = 8'h00;
    reset = 1'b1;
    tick();
    // strobe during reset must be ignored
    bus_if.out_strobe = 1'b1;
    bus_if.out_data   = 8'h77;
    tick();
    bus_if.out_strobe = 1'b0;
    reset = 1'b0;
    check("rst_tx",    {31'b0, tx}, 32'd1);
    check("rst_busy",  {31'b0, busy}, 32'd0);
    check("rst_count", {27'b0, fifo_count}, 32'd0);
    check("rst_full",  {31'b0, full}, 32'd0);
    check("rst_drop",  {24'b0, dropped}, 32'd0);
    tick();
    check("rst_idle_tx", {31'b0, tx}, 32'd1);

    // Single byte 0xA5: enqueue, pop next edge, 40-cycle frame
    strobe(8'hA5);
    check("a5_count_q", {27'b0, fifo_count}, 32'd1);
    check("a5_busy_q",  {31'b0, busy}, 32'd0);
    check("a5_tx_q",    {31'b0, tx}, 32'd1);
    tick();
    check("a5_count_pop", {27'b0, fifo_count}, 32'd0);
    check_frame(8'hA5, 0);

    // Three back-to-back strobes
    bus_if.out_strobe = 1'b1;
    bus_if.out_data   = 8'h01;
    tick();
    bus_if.out_data   = 8'h02;
    tick();
    check("b2b_count_e1", {27'b0, fifo_count}, 32'd1);
    check("b2b_tx_e1",    {31'b0, tx}, 32'd0);
    bus_if.out_data   = 8'h03;
    tick();
    bus_if.out_strobe = 1'b0;
    check("b2b_count_peak", {27'b0, fifo_count}, 32'd2);
    check_frame(8'h01, 1);
    check("b2b_count_idle1", {27'b0, fifo_count}, 32'd2);
    tick();
    check_frame(8'h02, 0);
    tick();
    check_frame(8'h03, 0);
    check("b2b_count_end", {27'b0, fifo_count}, 32'd0);

    // Six strobes while first frame in flight: 1 in flight, 4 queued, 1 dropped
    bus_if.out_strobe = 1'b1;
    for (int unsigned k = 0; k < 6; k++) begin
      bus_if.out_data = 8'h10 + 8'(k);
      tick();
    end
    bus_if.out_strobe = 1'b0;
    check("ovf_count", {27'b0, fifo_count}, 32'd4);
    check("ovf_full",  {31'b0, full}, 32'd1);
    check("ovf_drop",  {24'b0, dropped}, 32'd1);
    check_frame(8'h10, 4);
    check("ovf_full_idle", {31'b0, full}, 32'd1);
    // push and pop on the same edge while full
    strobe(8'h16);
    check("pp_count", {27'b0, fifo_count}, 32'd4);
    check("pp_drop",  {24'b0, dropped}, 32'd1);
    check("pp_tx",    {31'b0, tx}, 32'd0);
    check_frame(8'h11, 0);
    tick();
    check_frame(8'h12, 0);
    tick();
    check_frame(8'h13, 0);
    tick();
    check_frame(8'h14, 0);
    tick();
    check_frame(8'h16, 0);
    check("pp_count_end", {27'b0, fifo_count}, 32'd0);

    // Reset at bit 3 of a frame with two bytes queued
    bus_if.out_strobe = 1'b1;
    bus_if.out_data   = 8'h20;
    tick();
    bus_if.out_data   = 8'h21;
    tick();
    bus_if.out_data   = 8'h22;
    tick();
    bus_if.out_strobe = 1'b0;
    check("mid_count", {27'b0, fifo_count}, 32'd2);
    for (int unsigned k = 0; k < 15; k++) tick();
    check("mid_tx_bit3", {31'b0, tx}, 32'd0);
    check("mid_busy",    {31'b0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_tx",    {31'b0, tx}, 32'd1);
    check("mid_rst_busy",  {31'b0, busy}, 32'd0);
    check("mid_rst_count", {27'b0, fifo_count}, 32'd0);
    saw_low = 1'b0;
    for (int unsigned k = 0; k < 60; k++) begin
      saw_low = saw_low | ~tx | busy;
      tick();
    end
    check("mid_no_frames", {31'b0, saw_low}, 32'd0);

    // 300 strobes with the FIFO held full: dropped saturates
    bus_if.out_strobe = 1'b1;
    for (int unsigned k = 0; k < 10; k++) begin
      bus_if.out_data = 8'(k);
      tick();
    end
    check("sat_drop_10", {24'b0, dropped}, 32'd5);
    for (int unsigned k = 10; k < 300; k++) begin
      bus_if.out_data = 8'(k);
      tick();
    end
    bus_if.out_strobe = 1'b0;
    check("sat_drop", {24'b0, dropped}, 32'd255);
    check("sat_full", {31'b0, full}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
